// File: rtl/sha512_block_ctrl_if.sv
// Handshake and datapath-strobe bundle between the SHA-512 block sequencer,
// its upstream message/padding front-end and the round-function datapath.
interface sha512_block_ctrl_if #(
   parameter int unsigned CNT_W = 7
);
   logic             input_valid;
   logic             input_ready;
   logic             output_valid;
   logic             output_ready;
   logic             k_restart;
   logic             w_load;
   logic             vars_load;
   logic             round_en;
   logic             h_add;
   logic [CNT_W-1:0] round_idx;
   logic             busy;

   // Environment side: offers blocks, consumes results, observes strobes.
   modport master (
      output input_valid,
      output output_ready,
      input  input_ready,
      input  output_valid,
      input  k_restart,
      input  w_load,
      input  vars_load,
      input  round_en,
      input  h_add,
      input  round_idx,
      input  busy
   );

   // Controller side.
   modport slave (
      input  input_valid,
      input  output_ready,
      output input_ready,
      output output_valid,
      output k_restart,
      output w_load,
      output vars_load,
      output round_en,
      output h_add,
      output round_idx,
      output busy
   );
endinterface

// File: rtl/sha512_block_ctrl.sv
// SHA-512 single-block compression sequencer: accept, ROUNDS rounds, H add, result handshake.
// Optional performance counters enabled by defining SHA512_BLOCK_CTRL_PERF_EN.
module sha512_block_ctrl #(
   parameter int unsigned ROUNDS = 80,
   parameter int unsigned CNT_W  = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   sha512_block_ctrl_if.slave   bus
`ifdef SHA512_BLOCK_CTRL_PERF_EN
   ,
   output logic [31:0]          blocks_done,
   output logic [31:0]          cycles_busy
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic             accept;
   logic             in_ready;
   logic             out_valid;
   logic             busy_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = ROUND;
         end
         ROUND: begin
            if (cnt == LAST_ROUND) state_nxt = FINAL;
            else                   cnt_nxt   = cnt + CNT_W'(1);
         end
         FINAL: state_nxt = DONE;
         DONE: begin
            if (bus.output_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are masked by rst so a reset cycle never disturbs the datapath.
   always_comb begin
      in_ready      = (state == IDLE);
      accept        = in_ready && bus.input_valid;
      busy_s        = (state != IDLE);
      out_valid     = (state == DONE) && !rst;
      bus.k_restart = accept && !rst;
      bus.w_load    = accept && !rst;
      bus.vars_load = accept && !rst;
      bus.round_en  = (state == ROUND) && !rst;
      bus.h_add     = (state == FINAL) && !rst;
      bus.round_idx = (state == ROUND) ? cnt : '0;
   end

   assign bus.input_ready  = in_ready;
   assign bus.output_valid = out_valid;
   assign bus.busy         = busy_s;

`ifdef SHA512_BLOCK_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         blocks_done <= '0;
         cycles_busy <= '0;
      end else begin
         if (out_valid && bus.output_ready) blocks_done <= blocks_done + 32'd1;
         if (busy_s && (cycles_busy != '1))  cycles_busy <= cycles_busy + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sha512_block_ctrl.sv
// Bench for sha512_block_ctrl: vector table, hand-written corner sequences and
// randomized traffic checked against a cycle-offset reference model.
module tb_sha512_block_ctrl;

   localparam int R  = 80;
   localparam int CW = 7;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha512_block_ctrl_if #(.CNT_W(CW)) bus ();

`ifdef SHA512_BLOCK_CTRL_PERF_EN
   logic [31:0] blocks_done;
   logic [31:0] cycles_busy;
`endif

   sha512_block_ctrl #(.ROUNDS(R), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus)
`ifdef SHA512_BLOCK_CTRL_PERF_EN
      ,
      .blocks_done (blocks_done),
      .cycles_busy (cycles_busy)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference model: a block is described only by its accept cycle; outputs
   // follow from the offset d = t - t0.
   bit m_active = 1'b0;
   int m_t0     = 0;
   int t        = 0;
   int m_bd     = 0;
   int m_cb     = 0;

   logic [14:0] cur_act;
   logic [14:0] cur_exp;

   // Layout: {ir, ov, k, w, vl, re, ha, idx[6:0], busy}
   function automatic logic [14:0] pk(bit ir, bit ov, bit k, bit w, bit vl,
                                      bit re, bit ha, logic [6:0] idx, bit bs);
      return {ir, ov, k, w, vl, re, ha, idx, bs};
   endfunction

   function automatic logic [14:0] act_vec();
      return {bus.input_ready, bus.output_valid, bus.k_restart, bus.w_load,
              bus.vars_load, bus.round_en, bus.h_add, bus.round_idx, bus.busy};
   endfunction

   function automatic logic [14:0] model_exp(bit v, bit rs);
      int d;
      if (!m_active) return pk(1, 0, v && !rs, v && !rs, v && !rs, 0, 0, 7'd0, 0);
      d = t - m_t0;
      if (d >= 1 && d <= R) return pk(0, 0, 0, 0, 0, !rs, 0, 7'(d - 1), 1);
      if (d == R + 1)       return pk(0, 0, 0, 0, 0, 0, !rs, 7'd0, 1);
      return pk(0, !rs, 0, 0, 0, 0, 0, 7'd0, 1);
   endfunction

   task automatic model_update(bit v, bit o, bit rs, logic [14:0] e);
      if (rs) begin
         m_active = 1'b0;
         m_bd     = 0;
         m_cb     = 0;
      end else begin
         if (e[0]) m_cb++;
         if (e[13] && o) m_bd++;
         if (!m_active) begin
            if (v) begin
               m_active = 1'b1;
               m_t0     = t;
            end
         end else if ((t - m_t0) >= R + 2 && o) begin
            m_active = 1'b0;
         end
      end
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, t, act, exp);
      end
   endtask

   task automatic step(bit v, bit o, bit rs, bit cmp, string name);
      bus.input_valid  = v;
      bus.output_ready = o;
      rst              = rs;
      @(negedge clk);
      cur_act = act_vec();
      cur_exp = model_exp(v, rs);
      if (cmp) begin
         check(name, 32'(cur_act), 32'(cur_exp));
`ifdef SHA512_BLOCK_CTRL_PERF_EN
         check({name, "_blocks_done"}, blocks_done, 32'(m_bd));
         check({name, "_cycles_busy"}, cycles_busy, 32'(m_cb));
`endif
      end
      model_update(v, o, rs, cur_exp);
      @(posedge clk);
      #1;
      t++;
   endtask

   typedef struct {
      bit    v;
      bit    o;
      bit    rs;
      int    n;
      bit    ir, ov, k, w, vl, re, ha, bs;
      int    idx0;
      int    inc;
      string name;
   } vec_t;

   vec_t tbl[17];
   int   acc[$];
   int   nov;
   logic [14:0] texp;

   initial begin
      tbl[0]  = '{0, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset"};
      tbl[1]  = '{0, 1, 0, 10,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle"};
      tbl[2]  = '{1, 1, 0, 1,   1, 0, 1, 1, 1, 0, 0, 0, 0, 0, "accept"};
      tbl[3]  = '{0, 1, 0, R,   0, 0, 0, 0, 0, 1, 0, 1, 0, 1, "round"};
      tbl[4]  = '{0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 1, 0, 0, "final"};
      tbl[5]  = '{1, 0, 0, 5,   0, 1, 0, 0, 0, 0, 0, 1, 0, 0, "hold"};
      tbl[6]  = '{1, 1, 0, 1,   0, 1, 0, 0, 0, 0, 0, 1, 0, 0, "handshake"};
      tbl[7]  = '{0, 1, 0, 2,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle2"};
      tbl[8]  = '{1, 1, 0, 1,   1, 0, 1, 1, 1, 0, 0, 0, 0, 0, "accept2"};
      tbl[9]  = '{0, 1, 0, 40,  0, 0, 0, 0, 0, 1, 0, 1, 0, 1, "round2"};
      tbl[10] = '{0, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0, 1, 40, 0, "rst_mid"};
      tbl[11] = '{0, 1, 0, 3,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst"};
      tbl[12] = '{1, 1, 0, 1,   1, 0, 1, 1, 1, 0, 0, 0, 0, 0, "accept3"};
      tbl[13] = '{0, 1, 0, R,   0, 0, 0, 0, 0, 1, 0, 1, 0, 1, "round3"};
      tbl[14] = '{0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 1, 1, 0, 0, "final3"};
      tbl[15] = '{0, 1, 0, 1,   0, 1, 0, 0, 0, 0, 0, 1, 0, 0, "done3"};
      tbl[16] = '{0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle3"};

      bus.input_valid  = 1'b0;
      bus.output_ready = 1'b0;
      rst              = 1'b1;
      step(0, 0, 1, 0, "init");

      for (int e = 0; e < 17; e++) begin
         for (int i = 0; i < tbl[e].n; i++) begin
            step(tbl[e].v, tbl[e].o, tbl[e].rs, 0, tbl[e].name);
            texp = pk(tbl[e].ir, tbl[e].ov, tbl[e].k, tbl[e].w, tbl[e].vl,
                      tbl[e].re, tbl[e].ha, 7'(tbl[e].idx0 + i * tbl[e].inc), tbl[e].bs);
            check({"vec_", tbl[e].name}, 32'(cur_act), 32'(texp));
         end
      end

      // Back-to-back: input_valid held high for three full blocks.
      step(0, 1, 1, 1, "b2b_rst");
      nov = 0;
      for (int i = 0; i < 3 * (R + 3); i++) begin
         step(1, 1, 0, 1, "b2b");
         if (cur_act[12]) acc.push_back(i);
         if (cur_act[13]) nov++;
      end
      step(0, 1, 0, 1, "b2b_tail");
      check("b2b_accepts", 32'(acc.size()), 32'd3);
      check("b2b_gap1", (acc.size() >= 2) ? 32'(acc[1] - acc[0]) : 32'hFFFF_FFFF, 32'(R + 3));
      check("b2b_gap2", (acc.size() >= 3) ? 32'(acc[2] - acc[1]) : 32'hFFFF_FFFF, 32'(R + 3));
      check("b2b_valids", 32'(nov), 32'd3);
`ifdef SHA512_BLOCK_CTRL_PERF_EN
      check("perf_blocks_3", blocks_done, 32'd3);
      check("perf_busy_246", cycles_busy, 32'(3 * (R + 2)));
      step(0, 1, 1, 1, "perf_rst");
      check("perf_blocks_clr", blocks_done, 32'd0);
      check("perf_busy_clr", cycles_busy, 32'd0);
`endif

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
              $urandom_range(0, 299) == 0, 1, "rand");
      end
      step(0, 1, 1, 1, "final_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
